// File: rtl/ped_pkg.sv
// Shared constants and types for the pedestrian crossing head.
// Segment bit order is gfedcba, active-high.
package ped_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;

    localparam logic [6:0] CYCLE_MAX = 7'd120;
    localparam logic [6:0] WALK_HI   = 7'd120;
    localparam logic [6:0] WALK_LO   = 7'd100;
    localparam logic [6:0] CLEAR_LO  = 7'd80;

    typedef enum logic [1:0] {
        PH_WALK,
        PH_CLEAR,
        PH_DONT_WALK
    } phase_t;

    // Repeated subtraction of ten; valid for inputs 0..99.
    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to seven-segment pattern with a blanking input.
module seg7_decoder
    import ped_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/pedestrian_crossing_signal.sv
// Pedestrian head: walk/hand lamps and clearance countdown,
// a pure registered function of the master timer and enable.
module pedestrian_crossing_signal
    import ped_pkg::*;
#(
    parameter logic [6:0] CYCLE_MAX = ped_pkg::CYCLE_MAX,
    parameter logic [6:0] WALK_HI   = ped_pkg::WALK_HI,
    parameter logic [6:0] WALK_LO   = ped_pkg::WALK_LO,
    parameter logic [6:0] CLEAR_LO  = ped_pkg::CLEAR_LO
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] master_timer,
    output logic [6:0] tens_digit,
    output logic [6:0] ones_digit,
    output logic       hand_light,
    output logic       walk_light
);

    phase_t     phase;
    logic [6:0] count;
    logic [7:0] bcd;
    logic       walk_d;
    logic       hand_d;
    logic       blank_tens;
    logic       blank_ones;
    logic [6:0] tens_seg;
    logic [6:0] ones_seg;

    always_comb begin
        phase = PH_DONT_WALK;
        if (master_timer > CYCLE_MAX) begin
            phase = PH_DONT_WALK;
        end else if (master_timer > WALK_LO && master_timer <= WALK_HI) begin
            phase = PH_WALK;
        end else if (master_timer > CLEAR_LO && master_timer <= WALK_LO) begin
            phase = PH_CLEAR;
        end
    end

    assign count = master_timer - CLEAR_LO;
    assign bcd   = bin2bcd(count);

    always_comb begin
        walk_d     = 1'b0;
        hand_d     = 1'b0;
        blank_tens = 1'b1;
        blank_ones = 1'b1;
        if (enable) begin
            case (phase)
                PH_WALK: walk_d = 1'b1;
                PH_CLEAR: begin
                    // Hand flashes with the timer's LSB during clearance.
                    hand_d     = master_timer[0];
                    blank_ones = 1'b0;
                    blank_tens = (bcd[7:4] == 4'd0);
                end
                default: hand_d = 1'b1;
            endcase
        end
    end

    seg7_decoder u_tens (
        .bcd   (bcd[7:4]),
        .blank (blank_tens),
        .seg   (tens_seg)
    );

    seg7_decoder u_ones (
        .bcd   (bcd[3:0]),
        .blank (blank_ones),
        .seg   (ones_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            walk_light <= 1'b0;
            hand_light <= 1'b1;
            tens_digit <= SEG_BLANK;
            ones_digit <= SEG_BLANK;
        end else begin
            walk_light <= walk_d;
            hand_light <= hand_d;
            tens_digit <= tens_seg;
            ones_digit <= ones_seg;
        end
    end

endmodule

// File: tb/tb_pedestrian_crossing_signal.sv
// Directed bench for the pedestrian crossing head.
module tb_pedestrian_crossing_signal;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [6:0] master_timer;
    logic [6:0] tens_digit;
    logic [6:0] ones_digit;
    logic       hand_light;
    logic       walk_light;

    int n_checks;
    int n_pass;

    logic [6:0] seg_ref [10];

    pedestrian_crossing_signal dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .master_timer (master_timer),
        .tens_digit   (tens_digit),
        .ones_digit   (ones_digit),
        .hand_light   (hand_light),
        .walk_light   (walk_light)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] outs();
        return {walk_light, hand_light, tens_digit, ones_digit};
    endfunction

    // Reference: {walk, hand, tens, ones} for a given timer and enable.
    function automatic logic [15:0] model(input int t, input bit en);
        int n;
        if (!en) return 16'h0;
        if (t > 120 || t <= 80) return {1'b0, 1'b1, 14'h0};
        if (t > 100) return {1'b1, 1'b0, 14'h0};
        n = t - 80;
        return {1'b0, t[0], (n < 10) ? 7'h00 : seg_ref[n / 10], seg_ref[n % 10]};
    endfunction

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic step(input int t, input bit en);
        master_timer = t[6:0];
        enable       = en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        seg_ref = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                    7'b1111111, 7'b1101111};
        n_checks = 0;
        n_pass   = 0;

        rst_n        = 1'b0;
        enable       = 1'b1;
        master_timer = 7'd110;
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs(), {1'b0, 1'b1, 14'h0});

        rst_n = 1'b1;
        step(110, 1);
        check("post_reset_walk", outs(), {1'b1, 1'b0, 14'h0});

        for (int t = 120; t >= 0; t--) begin
            step(t, 1);
            check($sformatf("sweep_t%0d", t), outs(), model(t, 1));
            if (t == 100)
                check("t100_20", outs(), {2'b00, 7'b1011011, 7'b0111111});
            if (t == 99)
                check("t99_19", outs(), {2'b01, 7'b0000110, 7'b1101111});
            if (t == 81)
                check("t81_1", outs(), {2'b01, 7'b0000000, 7'b0000110});
        end

        step(127, 1);
        check("wrap_127", outs(), {1'b0, 1'b1, 14'h0});
        step(121, 1);
        check("oor_121", outs(), {1'b0, 1'b1, 14'h0});

        step(95, 1);
        check("clear_15", outs(), {2'b01, 7'b0000110, 7'b1101101});
        step(95, 0);
        check("disabled", outs(), 16'h0);
        step(95, 1);
        check("reenabled_15", outs(), {2'b01, 7'b0000110, 7'b1101101});

        step(110, 1);
        check("walk_before_rst", outs(), {1'b1, 1'b0, 14'h0});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), {1'b0, 1'b1, 14'h0});
        @(negedge clk);
        rst_n = 1'b1;

        step(120, 1);
        check("jump_from_120", outs(), {1'b1, 1'b0, 14'h0});
        step(85, 1);
        check("jump_to_85", outs(), {2'b01, 7'b0000000, 7'b1101101});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pedestrian_crossing_signal.md
Name: pedestrian_crossing_signal

Overview:
- Pedestrian-crossing head controller for one intersection approach.
- Consumes the shared master countdown timer (seconds left in the 120 s signal cycle, counting down) and an enable.
- Drives the walk lamp, the hand lamp and a two-digit seven-segment crossing countdown.
- Sits beside the vehicle light controllers, all slaved to the same master timer.

Parameters:
- CYCLE_MAX, 120, largest valid master_timer value; anything above it is out of range.
- WALK_HI, 120, walk phase starts when timer <= WALK_HI.
- WALK_LO, 100, walk phase ends; clearance phase runs while timer <= WALK_LO.
- CLEAR_LO, 80, clearance phase ends when timer <= CLEAR_LO. Requirement: WALK_LO - CLEAR_LO <= 99.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  1 = head active; 0 = head dark
- master_timer  input  7  seconds remaining in cycle, unsigned, decrements externally
- tens_digit  output  7  seven-segment tens digit, bit0=a … bit6=g, active-high
- ones_digit  output  7  seven-segment ones digit, same encoding
- hand_light  output  1  don't-walk (hand) lamp, active-high
- walk_light  output  1  walk lamp, active-high

Behaviour:
- All outputs are registered. Each output reflects master_timer and enable sampled on the previous rising clk edge, so latency is 1 cycle.
- Reset (rst_n=0, asynchronous):
  - walk_light=0, hand_light=1
  - tens_digit=ones_digit=7'b0000000 (blank)
  - Normal operation resumes on the first clk edge after deassertion.
- Phase decode on t = master_timer (combinational, then registered):
  - WALK: WALK_LO < t <= WALK_HI → walk=1, hand=0, both digits blank.
  - CLEAR: CLEAR_LO < t <= WALK_LO → walk=0, hand=t[0] (flashes, toggling each timer decrement). Display shows n = t - CLEAR_LO in decimal (range 1..20 with defaults).
  - DONT_WALK: t <= CLEAR_LO, or t > CYCLE_MAX (covers 121..127, including the 0→127 wrap) → walk=0, hand=1, both digits blank.
- enable=0 overrides the phase: walk=0, hand=0, both digits blank. Phase is recomputed directly from t when enable returns to 1; no internal state is kept.
- Display in CLEAR:
  - ones = n mod 10; tens = n / 10.
  - Tens digit blanks when n < 10 (leading-zero suppression); ones digit is always shown.
- Segment codes (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - blank=0000000
- walk_light and hand_light are never both 1.
- The block holds no counters. Behaviour is a pure registered function of (t, enable), so arbitrary timer jumps are handled correctly.
- Binary-to-BCD conversion uses compare/subtract on 7-bit unsigned values. Division and modulo operators are not permitted in the synthesized path.

Decomposition:
- Shared package ped_pkg:
  - SEG_BLANK and the SEG_0..SEG_9 constants
  - phase enum {PH_WALK, PH_CLEAR, PH_DONT_WALK}
  - default timing constants (CYCLE_MAX, WALK_HI, WALK_LO, CLEAR_LO)
- One sub-module seg7_decoder: 4-bit BCD plus blank input → 7-bit segment pattern. Instantiated twice (tens and ones).

Test Plan:
- Reset: hold rst_n=0 with enable=1, t=110 → hand=1, walk=0, digits 0000000. Release rst_n; after one clk → walk=1, hand=0, digits blank.
- Full sweep: enable=1, t from 120 down to 0, one decrement per clk, checking each cycle one clk later:
  - t=120..101 → walk=1, hand=0, digits blank.
  - t=100 → tens=1011011, ones=0111111 ("20"), hand=0.
  - t=99 → "19", hand=1.
  - t=81 → tens blank, ones=0000110, hand=1.
  - t=80..0 → hand=1, walk=0, digits blank.
- Wrap/out-of-range: t=127 and t=121 → hand=1, walk=0, digits blank.
- Enable: in CLEAR at t=95 (display "15"), drive enable=0 → next clk all outputs 0. Restore enable=1 → next clk shows "15" again and hand=t[0]=1.
- Asynchronous reset mid-WALK: assert rst_n=0 between clk edges at t=110 → outputs go to reset values immediately, without waiting for a clk edge.
- Jump: step t from 120 directly to 85 → next clk shows tens blank, ones=1101101 ("5"), hand=1, walk=0.
